// File: rtl/ram_pkg.sv
// Shared types and helpers for the banked RAM with range-clear engine.
package ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Number of words in the range first..last inclusive, wrapping at 2**aw.
    // The caller keeps the low aw+1 bits, which is enough for a full sweep.
    function automatic logic [31:0] range_len(input logic [31:0] first,
                                               input logic [31:0] last,
                                               input int unsigned aw);
        logic [31:0] wrap_mask;
        wrap_mask = (32'd1 << aw) - 32'd1;
        return ((last - first) & wrap_mask) + 32'd1;
    endfunction

endpackage

// File: rtl/ram_bank_be.sv
// One bank: write/read port with byte enables plus an always-on read port.
module ram_bank_be #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    sclr,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    re,
    output logic [DATA_WIDTH-1:0]   q_a,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    output logic [DATA_WIDTH-1:0]   q_b
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-masked write into the array.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // Registered reads; same-cycle writes are seen as old data.
    always_ff @(posedge clk) begin
        if (sclr) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            if (re) q_a <= mem[addr];
            q_b <= mem[b_addr];
        end
    end

endmodule

// File: rtl/ram_banked_clear.sv
// Multi-bank two-port RAM with reset-time init and a programmable range clear.
module ram_banked_clear
    import ram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    NUM_BANKS  = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    localparam int                   BANK_BITS  = $clog2(NUM_BANKS)
) (
    input  logic                          clk,
    input  logic                          sclr,
    input  logic                          a_valid,
    output logic                          a_ready,
    input  logic                          a_write,
    input  logic [BANK_BITS+ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH/8-1:0]       a_be,
    input  logic [DATA_WIDTH-1:0]         a_data,
    output logic [DATA_WIDTH-1:0]         q_a,
    output logic                          a_rvalid,
    input  logic [BANK_BITS+ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0]         q_b,
    input  logic                          clr_req,
    input  logic [NUM_BANKS-1:0]          clr_mask,
    input  logic [ADDR_WIDTH-1:0]         clr_first,
    input  logic [ADDR_WIDTH-1:0]         clr_last,
    input  logic [DATA_WIDTH-1:0]         clr_value,
    output logic                          busy,
    output logic                          clr_done
);

    localparam int AW_FULL = BANK_BITS + ADDR_WIDTH;

    clr_state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic [NUM_BANKS-1:0]  mask_q;
    logic [DATA_WIDTH-1:0] value_q;
    logic                  done_q;
    logic                  rvalid_q;
    logic [BANK_BITS-1:0]  a_sel_q;
    logic [BANK_BITS-1:0]  b_sel_q;

    logic [BANK_BITS-1:0]  a_bank;
    logic [BANK_BITS-1:0]  b_bank;
    logic                  a_fire;
    logic                  clr_accept;
    logic                  sweep_end;

    logic [NUM_BANKS-1:0]    bank_we;
    logic [NUM_BANKS-1:0]    bank_re;
    logic [DATA_WIDTH/8-1:0] bank_be;
    logic [ADDR_WIDTH-1:0]   bank_addr;
    logic [DATA_WIDTH-1:0]   bank_wdata;
    logic [DATA_WIDTH-1:0]   bank_q_a [NUM_BANKS];
    logic [DATA_WIDTH-1:0]   bank_q_b [NUM_BANKS];

    assign a_bank     = a_addr[AW_FULL-1 -: BANK_BITS];
    assign b_bank     = b_addr[AW_FULL-1 -: BANK_BITS];
    assign a_ready    = (state_q == IDLE) && !sclr;
    assign a_fire     = a_valid && a_ready;
    assign clr_accept = clr_req && (state_q == IDLE) && !sclr;
    assign sweep_end  = (state_q == CLEAR) && (cnt_q == (ADDR_WIDTH+1)'(1)) && !sclr;

    assign busy     = (state_q == CLEAR);
    assign clr_done = done_q;
    assign a_rvalid = rvalid_q;
    assign q_a      = bank_q_a[a_sel_q];
    assign q_b      = bank_q_b[b_sel_q];

    // State register; reset lands in CLEAR so the init sweep runs.
    always_ff @(posedge clk) begin
        if (sclr) state_q <= CLEAR;
        else      state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clr_accept) state_d = CLEAR;
            CLEAR:   if (sweep_end)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sweep pointer/counter, captured clear parameters and read bookkeeping.
    always_ff @(posedge clk) begin
        if (sclr) begin
            ptr_q    <= '0;
            cnt_q    <= {1'b1, {ADDR_WIDTH{1'b0}}};
            mask_q   <= '1;
            value_q  <= INIT_VALUE;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            a_sel_q  <= '0;
            b_sel_q  <= '0;
        end else begin
            done_q   <= sweep_end;
            rvalid_q <= a_fire && !a_write;
            b_sel_q  <= b_bank;
            if (a_fire && !a_write) a_sel_q <= a_bank;
            if (clr_accept) begin
                ptr_q   <= clr_first;
                cnt_q   <= (ADDR_WIDTH+1)'(range_len(32'(clr_first), 32'(clr_last), ADDR_WIDTH));
                mask_q  <= clr_mask;
                value_q <= clr_value;
            end else if (state_q == CLEAR) begin
                ptr_q <= ptr_q + 1'b1;
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Bank port mux: the sweep owns the write port while clearing, port A otherwise.
    always_comb begin
        bank_we    = '0;
        bank_re    = '0;
        bank_be    = a_be;
        bank_addr  = a_addr[ADDR_WIDTH-1:0];
        bank_wdata = a_data;
        if ((state_q == CLEAR) && !sclr) begin
            bank_we    = mask_q;
            bank_be    = '1;
            bank_addr  = ptr_q;
            bank_wdata = value_q;
        end else if (a_fire) begin
            if (a_write) bank_we[a_bank] = 1'b1;
            else         bank_re[a_bank] = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        ram_bank_be #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_bank (
            .clk    (clk),
            .sclr   (sclr),
            .we     (bank_we[g]),
            .be     (bank_be),
            .addr   (bank_addr),
            .wdata  (bank_wdata),
            .re     (bank_re[g]),
            .q_a    (bank_q_a[g]),
            .b_addr (b_addr[ADDR_WIDTH-1:0]),
            .q_b    (bank_q_b[g])
        );
    end

endmodule

// File: tb/tb_ram_banked_clear.sv
// Directed plus randomized bench for ram_banked_clear against a word-array model.
module tb_ram_banked_clear;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int NB    = 4;
    localparam int DEPTH = 16;
    localparam logic [DW-1:0] INIT = 16'hA5A5;

    logic          clk = 1'b0;
    logic          sclr;
    logic          a_valid;
    logic          a_ready;
    logic          a_write;
    logic [5:0]    a_addr;
    logic [1:0]    a_be;
    logic [DW-1:0] a_data;
    logic [DW-1:0] q_a;
    logic          a_rvalid;
    logic [5:0]    b_addr;
    logic [DW-1:0] q_b;
    logic          clr_req;
    logic [NB-1:0] clr_mask;
    logic [AW-1:0] clr_first;
    logic [AW-1:0] clr_last;
    logic [DW-1:0] clr_value;
    logic          busy;
    logic          clr_done;

    logic [DW-1:0] m [NB][DEPTH];
    int checks = 0;
    int errors = 0;

    ram_banked_clear #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_BANKS (NB),
        .INIT_VALUE(INIT)
    ) dut (
        .clk(clk), .sclr(sclr),
        .a_valid(a_valid), .a_ready(a_ready), .a_write(a_write),
        .a_addr(a_addr), .a_be(a_be), .a_data(a_data),
        .q_a(q_a), .a_rvalid(a_rvalid),
        .b_addr(b_addr), .q_b(q_b),
        .clr_req(clr_req), .clr_mask(clr_mask), .clr_first(clr_first),
        .clr_last(clr_last), .clr_value(clr_value),
        .busy(busy), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_fill(input logic [DW-1:0] v);
        for (int b = 0; b < NB; b++)
            for (int w = 0; w < DEPTH; w++) m[b][w] = v;
    endtask

    // Called right after sclr drops: init sweep lasts DEPTH cycles, then done + ready.
    task automatic check_reset_release(input string tag);
        int n = 0;
        int early = 0;
        while (a_ready !== 1'b1 && n < 100) begin
            if (clr_done !== 1'b0) early++;
            step();
            n++;
        end
        chk({tag, "_init_len"}, n, DEPTH);
        chk({tag, "_early_done"}, early, 0);
        chk({tag, "_done_pulse"}, clr_done, 1);
        chk({tag, "_busy_low"}, busy, 0);
        model_fill(INIT);
        step();
        chk({tag, "_done_clear"}, clr_done, 0);
    endtask

    task automatic wr(input logic [5:0] addr, input logic [1:0] be, input logic [DW-1:0] data,
                      input logic [5:0] baddr);
        logic [DW-1:0] exp_b;
        exp_b   = m[baddr[5:4]][baddr[3:0]];
        a_valid = 1'b1; a_write = 1'b1; a_addr = addr; a_be = be; a_data = data;
        b_addr  = baddr;
        step();
        a_valid = 1'b0;
        for (int i = 0; i < 2; i++)
            if (be[i]) m[addr[5:4]][addr[3:0]][i*8 +: 8] = data[i*8 +: 8];
        chk("wr_portb_old", q_b, exp_b);
        chk("wr_no_rvalid", a_rvalid, 0);
    endtask

    task automatic rd(input logic [5:0] addr, input logic [5:0] baddr);
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
        exp_a   = m[addr[5:4]][addr[3:0]];
        exp_b   = m[baddr[5:4]][baddr[3:0]];
        a_valid = 1'b1; a_write = 1'b0; a_addr = addr; b_addr = baddr;
        step();
        a_valid = 1'b0;
        chk("rd_q_a", q_a, exp_a);
        chk("rd_rvalid", a_rvalid, 1);
        chk("rd_q_b", q_b, exp_b);
        step();
        chk("rd_rvalid_pulse", a_rvalid, 0);
        chk("rd_q_a_hold", q_a, exp_a);
    endtask

    task automatic clr(input logic [NB-1:0] mask, input logic [AW-1:0] first,
                       input logic [AW-1:0] last, input logic [DW-1:0] value);
        int len;
        int n = 0;
        clr_req = 1'b1; clr_mask = mask; clr_first = first; clr_last = last; clr_value = value;
        step();
        clr_req = 1'b0;
        len = ((int'(last) - int'(first) + DEPTH) % DEPTH) + 1;
        while (busy === 1'b1 && n < 300) begin
            step();
            n++;
        end
        chk("clr_len", n, len);
        chk("clr_done_pulse", clr_done, 1);
        chk("clr_ready", a_ready, 1);
        for (int i = 0; i < len; i++)
            for (int b = 0; b < NB; b++)
                if (mask[b]) m[b][(int'(first) + i) % DEPTH] = value;
        step();
        chk("clr_done_once", clr_done, 0);
    endtask

    task automatic read_all();
        for (int b = 0; b < NB; b++)
            for (int w = 0; w < DEPTH; w++)
                rd({2'(b), 4'(w)}, 6'($urandom_range(0, 63)));
    endtask

    initial begin
        sclr = 1'b1; a_valid = 1'b0; a_write = 1'b0; a_addr = '0; a_be = '0; a_data = '0;
        b_addr = '0; clr_req = 1'b0; clr_mask = '0; clr_first = '0; clr_last = '0; clr_value = '0;

        // Reset state and init sweep.
        repeat (3) step();
        chk("rst_busy", busy, 1);
        chk("rst_ready", a_ready, 0);
        chk("rst_rvalid", a_rvalid, 0);
        chk("rst_done", clr_done, 0);
        chk("rst_q_a", q_a, 0);
        chk("rst_q_b", q_b, 0);
        sclr = 1'b0;
        check_reset_release("rst");
        read_all();

        // Byte enables.
        wr({2'd2, 4'd5}, 2'b01, 16'h1234, 6'd0);
        rd({2'd2, 4'd5}, 6'd1);
        chk("be_low_byte", q_a, 16'hA534);
        wr({2'd2, 4'd5}, 2'b00, 16'hFFFF, 6'd2);
        rd({2'd2, 4'd5}, 6'd3);
        chk("be_zero_noop", q_a, 16'hA534);
        wr({2'd2, 4'd5}, 2'b10, 16'h7700, {2'd2, 4'd5});
        rd({2'd2, 4'd5}, {2'd2, 4'd5});
        chk("be_high_byte", q_a, 16'h7734);

        // Wrap-around clear on banks 0 and 2.
        clr(4'b0101, 4'd14, 4'd1, 16'h0000);
        rd({2'd0, 4'd15}, 6'd0);
        chk("wrap_b0_w15", q_a, 16'h0000);
        rd({2'd1, 4'd14}, 6'd0);
        chk("wrap_b1_w14", q_a, 16'hA5A5);
        rd({2'd2, 4'd2}, 6'd0);
        chk("wrap_b2_w2", q_a, 16'hA5A5);
        read_all();

        // Clear request colliding with a port A write; second request during busy ignored.
        a_valid = 1'b1; a_write = 1'b1; a_addr = {2'd1, 4'd3}; a_be = 2'b11; a_data = 16'hBEEF;
        clr_req = 1'b1; clr_mask = 4'b0010; clr_first = 4'd3; clr_last = 4'd3; clr_value = 16'h0000;
        step();
        a_valid = 1'b0;
        m[1][3] = 16'h0000;
        chk("coll_busy", busy, 1);
        chk("coll_ready_low", a_ready, 0);
        clr_mask = 4'b1111; clr_first = 4'd0; clr_last = 4'd15; clr_value = 16'hFFFF;
        step();
        clr_req = 1'b0;
        chk("coll_single_len", busy, 0);
        chk("coll_done", clr_done, 1);
        step();
        chk("coll_ignored", busy, 0);
        rd({2'd1, 4'd3}, 6'd0);
        chk("coll_word", q_a, 16'h0000);
        rd({2'd3, 4'd9}, 6'd0);
        chk("coll_no_fill", q_a, 16'hA5A5);

        // Port B observing a word while the sweep rewrites it.
        wr({2'd0, 4'd15}, 2'b11, 16'h1357, 6'd0);
        b_addr = {2'd0, 4'd15};
        clr_req = 1'b1; clr_mask = 4'b0001; clr_first = 4'd0; clr_last = 4'd15; clr_value = 16'h2468;
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 17; k++) begin
            chk("portb_old_during_clear", q_b, 16'h1357);
            step();
        end
        chk("portb_new_after_clear", q_b, 16'h2468);
        for (int w = 0; w < DEPTH; w++) m[0][w] = 16'h2468;
        step();

        // Reset during a clear aborts it and reruns init.
        clr_req = 1'b1; clr_mask = 4'b1111; clr_first = 4'd0; clr_last = 4'd15; clr_value = 16'hFFFF;
        step();
        clr_req = 1'b0;
        step();
        step();
        sclr = 1'b1;
        step();
        chk("abort_busy", busy, 1);
        chk("abort_no_done", clr_done, 0);
        sclr = 1'b0;
        check_reset_release("abort");
        read_all();

        // Randomized traffic against the model.
        for (int i = 0; i < 150; i++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 5)
                wr(6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), 16'($urandom),
                   6'($urandom_range(0, 63)));
            else if (op < 9)
                rd(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
            else
                clr(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 16'($urandom));
        end
        clr(4'b0000, 4'd7, 4'd6, 16'hDEAD);
        read_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
